// File: rtl/note_pkg.sv
// Shared types and constants for the string note scheduler: FSM state, field widths,
// and the transpose saturation helper.
package note_pkg;

    localparam int NOTE_W        = 6;
    localparam int OCT_W         = 3;
    localparam int SEMI_W        = 4;
    localparam int STR_W         = 3;
    localparam int SEMIS_PER_OCT = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    // Clamp a signed transposed note into the playable 0..63 range.
    function automatic logic [NOTE_W-1:0] sat_note(input logic signed [7:0] sum);
        logic [NOTE_W-1:0] res;
        if (sum < 8'sd0) begin
            res = 6'd0;
        end else if (sum > 8'sd63) begin
            res = 6'd63;
        end else begin
            res = sum[NOTE_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/note_div12.sv
// Combinational divide-by-12 for 6-bit note numbers: octave = note / 12, semitone = note % 12.
module note_div12
    import note_pkg::*;
(
    input  logic [NOTE_W-1:0] note,
    output logic [OCT_W-1:0]  octave,
    output logic [SEMI_W-1:0] semitone
);

    logic [NOTE_W-1:0] base_s;

    // Threshold compare against multiples of 12 instead of a generic divider.
    always_comb begin
        octave = 3'd0;
        base_s = 6'd0;
        if (note >= 6'd60) begin
            octave = 3'd5;
            base_s = 6'd60;
        end else if (note >= 6'd48) begin
            octave = 3'd4;
            base_s = 6'd48;
        end else if (note >= 6'd36) begin
            octave = 3'd3;
            base_s = 6'd36;
        end else if (note >= 6'd24) begin
            octave = 3'd2;
            base_s = 6'd24;
        end else if (note >= 6'd12) begin
            octave = 3'd1;
            base_s = 6'd12;
        end else begin
            octave = 3'd0;
            base_s = 6'd0;
        end
        semitone = SEMI_W'(note - base_s);
    end

endmodule

// File: rtl/string_note_scheduler.sv
// Round-robin scheduler collecting note requests from up to 8 strings and emitting
// octave/semitone pairs. Optional feature macro: NOTE_SCHED_TRANSPOSE_EN (adds transpose input).
module string_note_scheduler
    import note_pkg::*;
#(
    parameter int NUM_STR = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_STR-1:0]         req_valid,
    input  logic [NOTE_W*NUM_STR-1:0]  req_note,
    output logic [NUM_STR-1:0]         req_ready,
`ifdef NOTE_SCHED_TRANSPOSE_EN
    input  logic signed [4:0]          transpose,
`endif
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [STR_W-1:0]           out_string,
    output logic [OCT_W-1:0]           out_octave,
    output logic [SEMI_W-1:0]          out_semitone,
    output logic                       busy
);

    state_t               state_r, state_s;
    logic [NUM_STR-1:0]   pending_r, pending_s, clr_s;
    logic [NOTE_W-1:0]    slot_note_r [NUM_STR];
    logic [STR_W-1:0]     ptr_r;
    logic [STR_W-1:0]     idx_r;
    logic [NOTE_W-1:0]    note_r, grant_note_s;
    logic                 grant_s, found_s;
    logic [STR_W-1:0]     grant_idx_s;
    logic [3:0]           cand_s, next_ptr_s;
    logic [7:0]           pend_ext_s;
    logic [OCT_W-1:0]     div_oct_s;
    logic [SEMI_W-1:0]    div_semi_s;
    logic                 out_valid_r;
    logic [STR_W-1:0]     out_string_r;
    logic [OCT_W-1:0]     out_octave_r;
    logic [SEMI_W-1:0]    out_semitone_r;

    assign req_ready    = ~pending_r;
    assign busy         = (pending_r != '0) || (state_r != IDLE);
    assign out_valid    = out_valid_r;
    assign out_string   = out_string_r;
    assign out_octave   = out_octave_r;
    assign out_semitone = out_semitone_r;

    // Round-robin search: first pending slot at or after the pointer, wrapping at NUM_STR.
    always_comb begin
        found_s     = 1'b0;
        grant_idx_s = 3'd0;
        cand_s      = 4'd0;
        pend_ext_s  = 8'(pending_r);
        for (int k = 0; k < NUM_STR; k++) begin
            cand_s = {1'b0, ptr_r} + 4'(k);
            cand_s = (cand_s >= 4'(NUM_STR)) ? (cand_s - 4'(NUM_STR)) : cand_s;
            if (!found_s && pend_ext_s[cand_s[2:0]]) begin
                found_s     = 1'b1;
                grant_idx_s = cand_s[2:0];
            end else begin
                found_s     = found_s;
            end
        end
        next_ptr_s = {1'b0, grant_idx_s} + 4'd1;
        next_ptr_s = (next_ptr_s >= 4'(NUM_STR)) ? 4'd0 : next_ptr_s;
    end

    // Next-state logic; out_valid lags OUTPUT entry by one cycle, so the handshake uses the register.
    always_comb begin
        state_s = state_r;
        grant_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    state_s = DECODE;
                    grant_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            DECODE: state_s = OUTPUT;
            OUTPUT: begin
                if (out_valid_r && out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = OUTPUT;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Slot bookkeeping: grant clears, a handshake on a free slot sets.
    always_comb begin
        clr_s     = grant_s ? (NUM_STR'(1) << grant_idx_s) : '0;
        pending_s = (pending_r & ~clr_s) | (req_valid & ~pending_r);
    end

    // Note presented to the divider after the grant, optionally transposed and clamped.
`ifdef NOTE_SCHED_TRANSPOSE_EN
    always_comb begin
        grant_note_s = sat_note($signed({2'b00, slot_note_r[grant_idx_s]}) +
                                $signed({{3{transpose[4]}}, transpose}));
    end
`else
    always_comb begin
        grant_note_s = slot_note_r[grant_idx_s];
    end
`endif

    // FSM state, pending flags and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            pending_r <= '0;
            ptr_r     <= 3'd0;
        end else begin
            state_r   <= state_s;
            pending_r <= pending_s;
            ptr_r     <= grant_s ? next_ptr_s[2:0] : ptr_r;
        end
    end

    // Per-string note capture on request handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STR; i++) begin
                slot_note_r[i] <= 6'd0;
            end
        end else begin
            for (int i = 0; i < NUM_STR; i++) begin
                if (req_valid[i] && !pending_r[i]) begin
                    slot_note_r[i] <= req_note[NOTE_W*i +: NOTE_W];
                end else begin
                    slot_note_r[i] <= slot_note_r[i];
                end
            end
        end
    end

    // Granted note and index latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            note_r <= 6'd0;
            idx_r  <= 3'd0;
        end else if (grant_s) begin
            note_r <= grant_note_s;
            idx_r  <= grant_idx_s;
        end else begin
            note_r <= note_r;
            idx_r  <= idx_r;
        end
    end

    note_div12 u_div (
        .note     (note_r),
        .octave   (div_oct_s),
        .semitone (div_semi_s)
    );

    // Output fields load only in DECODE, so they hold through OUTPUT and idle periods.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_string_r   <= 3'd0;
            out_octave_r   <= 3'd0;
            out_semitone_r <= 4'd0;
        end else if (state_r == DECODE) begin
            out_string_r   <= idx_r;
            out_octave_r   <= div_oct_s;
            out_semitone_r <= div_semi_s;
        end else begin
            out_string_r   <= out_string_r;
            out_octave_r   <= out_octave_r;
            out_semitone_r <= out_semitone_r;
        end
    end

    // out_valid rises one cycle into OUTPUT and drops on the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
        end else if (state_r == OUTPUT) begin
            out_valid_r <= !(out_valid_r && out_ready);
        end else begin
            out_valid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_string_note_scheduler.sv
// Directed bench for string_note_scheduler with hand-computed expected octave/semitone values.
module tb_string_note_scheduler;
    localparam int NS = 6;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NS-1:0]   req_valid;
    logic [6*NS-1:0] req_note;
    logic [NS-1:0]   req_ready;
    logic            out_valid;
    logic            out_ready;
    logic [2:0]      out_string;
    logic [2:0]      out_octave;
    logic [3:0]      out_semitone;
    logic            busy;
`ifdef NOTE_SCHED_TRANSPOSE_EN
    logic signed [4:0] transpose;
`endif

    int n_cmp = 0;
    int n_err = 0;

    string_note_scheduler #(.NUM_STR(NS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_note     (req_note),
        .req_ready    (req_ready),
`ifdef NOTE_SCHED_TRANSPOSE_EN
        .transpose    (transpose),
`endif
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_string   (out_string),
        .out_octave   (out_octave),
        .out_semitone (out_semitone),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input int s, input int note);
        req_valid[s] = 1'b1;
        req_note[6*s +: 6] = 6'(note);
    endtask

    // Advance negedge by negedge until out_valid is seen (bounded).
    task automatic wait_out();
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) check_eq("wait_out_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_out(input string tag, input int s, input int oct, input int semi);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_string"}, 32'(out_string), 32'(s));
        check_eq({tag, "_octave"}, 32'(out_octave), 32'(oct));
        check_eq({tag, "_semitone"}, 32'(out_semitone), 32'(semi));
    endtask

    int exp_oct  [NS] = '{0, 1, 2, 3, 4, 5};
    int exp_semi [NS] = '{0, 0, 0, 0, 0, 3};
    int notes    [NS] = '{0, 12, 24, 36, 48, 63};

    initial begin
        int seen;
        rst_n = 1'b0;
        req_valid = '0;
        req_note = '0;
        out_ready = 1'b1;
`ifdef NOTE_SCHED_TRANSPOSE_EN
        transpose = 5'sd0;
`endif
        #2;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_req_ready", 32'(req_ready), 32'h3F);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_octave", 32'(out_octave), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single request: string 2, note 37, latency of three edges.
        drive_req(2, 37);
        @(negedge clk);
        req_valid = '0;
        check_eq("lat_n0_valid", 32'(out_valid), 32'd0);
        check_eq("lat_n0_ready2", 32'(req_ready[2]), 32'd0);
        check_eq("lat_n0_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check_eq("lat_n1_valid", 32'(out_valid), 32'd0);
        check_eq("slot_reuse_ready2", 32'(req_ready[2]), 32'd1);
        @(negedge clk);
        check_eq("lat_n2_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check_out("lat_n3", 2, 3, 1);
        @(negedge clk);
        check_eq("after_hs_valid", 32'(out_valid), 32'd0);
        check_eq("hold_string", 32'(out_string), 32'd2);
        check_eq("hold_octave", 32'(out_octave), 32'd3);
        check_eq("idle_busy", 32'(busy), 32'd0);

        // Reset, then all strings at once: served 0..5.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NS; i++) drive_req(i, notes[i]);
        @(negedge clk);
        req_valid = '0;
        for (int i = 0; i < NS; i++) begin
            wait_out();
            check_out($sformatf("all_%0d", i), i, exp_oct[i], exp_semi[i]);
        end
        @(negedge clk);

        // Back-pressure: string 1 note 50 held 4 cycles; string 4 note 29 arrives meanwhile.
        out_ready = 1'b0;
        drive_req(1, 50);
        @(negedge clk);
        req_valid = '0;
        wait_out();
        drive_req(4, 29);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req_valid = '0;
            check_out($sformatf("stall_%0d", i), 1, 4, 2);
            check_eq("stall_ready4", 32'(req_ready[4]), 32'd0);
        end
        out_ready = 1'b1;
        wait_out();
        check_out("after_stall", 4, 2, 5);

        // Wrap: pointer at 5 with strings 0 and 5 pending -> 5 first, then 0.
        drive_req(0, 11);
        drive_req(5, 12);
        @(negedge clk);
        req_valid = '0;
        wait_out();
        check_out("wrap_first", 5, 1, 0);
        wait_out();
        check_out("wrap_second", 0, 0, 11);

        // Reset during DECODE discards the note.
        drive_req(3, 40);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        check_eq("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_semitone", 32'(out_semitone), 32'd0);
        check_eq("mid_rst_ready", 32'(req_ready), 32'h3F);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check_eq("post_rst_no_output", 32'(seen), 32'd0);

`ifdef NOTE_SCHED_TRANSPOSE_EN
        transpose = 5'sd10;
        drive_req(0, 60);
        @(negedge clk);
        req_valid = '0;
        wait_out();
        check_out("tr_sat_hi", 0, 5, 3);
        @(negedge clk);
        transpose = -5'sd8;
        drive_req(1, 5);
        @(negedge clk);
        req_valid = '0;
        wait_out();
        check_out("tr_sat_lo", 1, 0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
